slow_dac_ctrl: RTL and testbench

//  Upstream feeder for the slow DAC serializer. Holds a shadow bank of N_CH 16-bit DAC codes written by the

---
 rtl/slow_dac_ctrl.sv | 141 ++++++++++++++
 tb/tb_slow_dac_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_dac_ctrl.sv
// Upstream feeder for the slow DAC serializer: shadows per-channel codes, snapshots them
// into a frozen frame, and holds dac_valid for exactly one serial frame followed by a gap.
module slow_dac_ctrl #(
    parameter int          N_CH        = 4,
    parameter int          CLK_DIV     = 3,
    parameter logic [3:0]  CMD         = 4'h3,
    parameter int          GAP_CYCLES  = 4,
    parameter int          REFRESH_DIV = 0,
    parameter logic [15:0] RESET_VAL   = 16'h8000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [2:0]           wr_addr,
    input  logic [15:0]          wr_data,
    input  logic                 update_req,
    output logic [16*N_CH-1:0]   dac_data,
    output logic                 dac_valid,
    output logic [3:0]           dac_cmd,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          frame_cnt
);

    // state | meaning
    // IDLE  | waiting for pending write, update_req or refresh tick
    // LOAD  | one cycle: snapshot shadow into dac_data, raise dac_valid
    // RUN   | dac_valid high, frame timer counting down to zero
    // GAP   | dac_valid low for GAP_CYCLES so the serializer can re-arm

    localparam int FRAME_CYCLES = 129 * (2 ** CLK_DIV);
    localparam int TMR_MAX      = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int TMR_W        = $clog2(TMR_MAX);
    localparam int REF_W        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_GAP
    } state_t;

    state_t               state, state_nxt;
    logic [16*N_CH-1:0]   shadow;
    logic                 pending, pending_nxt;
    logic [TMR_W-1:0]     tmr;
    logic                 wr_ok;
    logic                 refresh_tick;
    logic                 tmr_zero;

    assign wr_ok    = wr_en && (int'(wr_addr) < N_CH);
    assign tmr_zero = (tmr == '0);
    assign dac_cmd  = CMD;
    assign busy     = (state != S_IDLE);

    for (genvar k = 0; k < N_CH; k++) begin : g_shadow
        always_ff @(posedge clk) begin
            if (rst) begin
                shadow[16*k +: 16] <= RESET_VAL;
            end else if (wr_ok && (wr_addr == 3'(k))) begin
                shadow[16*k +: 16] <= wr_data;
            end
        end
    end

    // Free-running; first tick arrives one full period after reset.
    if (REFRESH_DIV > 0) begin : g_refresh
        logic [REF_W-1:0] ref_cnt;
        assign refresh_tick = (ref_cnt == REF_W'(REFRESH_DIV - 1));
        always_ff @(posedge clk) begin
            if (rst) begin
                ref_cnt <= '0;
            end else if (refresh_tick) begin
                ref_cnt <= '0;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
        end
    end else begin : g_no_refresh
        assign refresh_tick = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        case (state)
            S_IDLE: if (pending || update_req || refresh_tick) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_RUN;
            S_RUN:  if (tmr_zero) state_nxt = S_GAP;
            S_GAP:  if (tmr_zero) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (state == S_LOAD) pending_nxt = 1'b0;
        // Requests that arrive while a frame is in flight are folded into one follow-up frame.
        if (wr_ok || ((state != S_IDLE) && (update_req || refresh_tick))) pending_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= 1'b0;
            dac_data   <= '0;
            dac_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            tmr        <= '0;
        end else begin
            pending    <= pending_nxt;
            frame_done <= 1'b0;
            case (state)
                S_LOAD: begin
                    dac_data  <= shadow;
                    dac_valid <= 1'b1;
                    tmr       <= TMR_W'(FRAME_CYCLES - 1);
                end
                S_RUN: begin
                    if (tmr_zero) begin
                        dac_valid  <= 1'b0;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        tmr        <= TMR_W'(GAP_CYCLES - 1);
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_GAP: begin
                    if (!tmr_zero) tmr <= tmr - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_slow_dac_ctrl.sv
// Directed bench for slow_dac_ctrl: frame length, snapshot timing, coalescing, reset abort,
// and autonomous refresh with frame counter wrap on a second instance.
module tb_slow_dac_ctrl;

    localparam int FRAME = 1032;
    localparam int GAPLOW = 6;   // frame_done cycle + remaining GAP + IDLE + LOAD

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        update_req = 1'b0;
    logic [63:0] dac_data;
    logic        dac_valid;
    logic [3:0]  dac_cmd;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;

    logic        rst_r = 1'b1;
    logic        wr_en_r = 1'b0;
    logic [2:0]  wr_addr_r = '0;
    logic [15:0] wr_data_r = '0;
    logic        update_req_r = 1'b0;
    logic [63:0] dac_data_r;
    logic        dac_valid_r;
    logic [3:0]  dac_cmd_r;
    logic        busy_r;
    logic        frame_done_r;
    logic [15:0] frame_cnt_r;

    int errors = 0;
    int checks = 0;

    slow_dac_ctrl dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .update_req(update_req), .dac_data(dac_data), .dac_valid(dac_valid), .dac_cmd(dac_cmd),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    slow_dac_ctrl #(.REFRESH_DIV(3000)) dut_r (
        .clk(clk), .rst(rst_r), .wr_en(wr_en_r), .wr_addr(wr_addr_r), .wr_data(wr_data_r),
        .update_req(update_req_r), .dac_data(dac_data_r), .dac_valid(dac_valid_r), .dac_cmd(dac_cmd_r),
        .busy(busy_r), .frame_done(frame_done_r), .frame_cnt(frame_cnt_r)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_en = 1'b0;
        update_req = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_ch(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Counts low cycles up to the next valid frame, then measures it; returns on the first low cycle.
    task automatic run_frame(output int gap, output int len, output logic [63:0] data,
                             output logic stable, output logic done);
        gap = 0;
        while (!dac_valid && gap < 5000) begin
            gap++;
            tick();
        end
        data = dac_data;
        stable = 1'b1;
        len = 0;
        while (dac_valid && len < 5000) begin
            len++;
            if (dac_data !== data) stable = 1'b0;
            tick();
        end
        done = frame_done;
    endtask

    task automatic test_reset();
        int seen_valid;
        int bad;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dac_valid); end
        checks++; if (dac_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h want 0", dac_data); end
        checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", frame_cnt); end
        checks++; if (dac_cmd !== 4'h3) begin errors++; $display("FAIL reset_cmd: got %h want 3", dac_cmd); end
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", busy, frame_done); end
        seen_valid = 0;
        bad = 0;
        repeat (5000) begin
            tick();
            if (dac_valid !== 1'b0) seen_valid++;
            if (dac_data !== 64'h0 || frame_cnt !== 16'h0 || busy !== 1'b0) bad++;
        end
        checks++; if (seen_valid != 0) begin errors++; $display("FAIL idle_no_valid: got %0d valid cycles want 0", seen_valid); end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_outputs: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_single_write();
        int gap, len;
        logic [63:0] data;
        logic stable, done;
        do_reset();
        write_ch(3'd2, 16'h1234);
        checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL lat_t0: got valid %b want 0", dac_valid); end
        tick();
        checks++; if (busy !== 1'b1 || dac_valid !== 1'b0) begin errors++; $display("FAIL lat_load: got busy %b valid %b want 1 0", busy, dac_valid); end
        tick();
        checks++; if (dac_valid !== 1'b1) begin errors++; $display("FAIL lat_t2: got valid %b want 1", dac_valid); end
        run_frame(gap, len, data, stable, done);
        checks++; if (len != FRAME) begin errors++; $display("FAIL single_len: got %0d want %0d", len, FRAME); end
        checks++; if (data !== 64'h8000_1234_8000_8000) begin errors++; $display("FAIL single_data: got %h want 8000123480008000", data); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL single_stable: got %b want 1", stable); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", done); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", frame_cnt); end
        tick();
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b want 0", frame_done); end
    endtask

    task automatic test_coalesce();
        int gap, len, seen;
        logic [63:0] data;
        logic stable, done;
        do_reset();
        update_req = 1'b1;
        tick();
        update_req = 1'b0;
        tick();
        checks++; if (dac_valid !== 1'b1) begin errors++; $display("FAIL upd_latency: got valid %b want 1", dac_valid); end
        write_ch(3'd0, 16'h0001);
        write_ch(3'd0, 16'h0002);
        write_ch(3'd1, 16'hFFFF);
        run_frame(gap, len, data, stable, done);
        checks++; if (len != FRAME - 3) begin errors++; $display("FAIL coal_len1: got %0d want %0d", len, FRAME - 3); end
        checks++; if (data !== 64'h8000_8000_8000_8000 || stable !== 1'b1) begin errors++; $display("FAIL coal_data1: got %h stable %b want 8000800080008000 1", data, stable); end
        run_frame(gap, len, data, stable, done);
        checks++; if (gap != GAPLOW) begin errors++; $display("FAIL coal_gap: got %0d want %0d", gap, GAPLOW); end
        checks++; if (len != FRAME) begin errors++; $display("FAIL coal_len2: got %0d want %0d", len, FRAME); end
        checks++; if (data !== 64'h8000_8000_FFFF_0002) begin errors++; $display("FAIL coal_data2: got %h want 80008000ffff0002", data); end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL coal_cnt: got %0d want 2", frame_cnt); end
        seen = 0;
        repeat (300) begin
            tick();
            if (dac_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL coal_extra_frame: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_load_write();
        int gap, len, seen;
        logic [63:0] data;
        logic stable, done;
        do_reset();
        write_ch(3'd1, 16'hAAAA);
        tick();
        checks++; if (busy !== 1'b1 || dac_valid !== 1'b0) begin errors++; $display("FAIL lw_in_load: got busy %b valid %b want 1 0", busy, dac_valid); end
        write_ch(3'd3, 16'h5555);
        run_frame(gap, len, data, stable, done);
        checks++; if (gap != 0 || len != FRAME) begin errors++; $display("FAIL lw_len1: got gap %0d len %0d want 0 %0d", gap, len, FRAME); end
        checks++; if (data !== 64'h8000_8000_AAAA_8000) begin errors++; $display("FAIL lw_data1: got %h want 80008000aaaa8000", data); end
        run_frame(gap, len, data, stable, done);
        checks++; if (data !== 64'h5555_8000_AAAA_8000) begin errors++; $display("FAIL lw_data2: got %h want 55558000aaaa8000", data); end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL lw_cnt: got %0d want 2", frame_cnt); end
        repeat (10) tick();
        write_ch(3'd5, 16'h1111);
        seen = 0;
        repeat (300) begin
            tick();
            if (dac_valid || busy) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL bad_addr_frame: got %0d active cycles want 0", seen); end
        update_req = 1'b1;
        tick();
        update_req = 1'b0;
        run_frame(gap, len, data, stable, done);
        checks++; if (data !== 64'h5555_8000_AAAA_8000) begin errors++; $display("FAIL bad_addr_shadow: got %h want 55558000aaaa8000", data); end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL bad_addr_cnt: got %0d want 3", frame_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int gap, len, seen;
        logic [63:0] data;
        logic stable, done;
        do_reset();
        write_ch(3'd0, 16'h7777);
        tick();
        tick();
        repeat (500) tick();
        checks++; if (dac_valid !== 1'b1 || dac_data !== 64'h8000_8000_8000_7777) begin errors++; $display("FAIL mid_before: got valid %b data %h want 1 8000800080007777", dac_valid, dac_data); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (dac_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_valid: got valid %b busy %b want 0 0", dac_valid, busy); end
        checks++; if (frame_cnt !== 16'd0 || dac_data !== 64'h0) begin errors++; $display("FAIL mid_clear: got cnt %0d data %h want 0 0", frame_cnt, dac_data); end
        seen = 0;
        repeat (50) begin
            if (frame_done || dac_valid) seen++;
            tick();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_done: got %0d cycles want 0", seen); end
        update_req = 1'b1;
        tick();
        update_req = 1'b0;
        run_frame(gap, len, data, stable, done);
        checks++; if (data !== 64'h8000_8000_8000_8000 || len != FRAME) begin errors++; $display("FAIL mid_shadow: got %h len %0d want 8000800080008000 %0d", data, len, FRAME); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL mid_cnt: got %0d want 1", frame_cnt); end
    endtask

    task automatic test_back_to_back();
        int gap, len, seen;
        logic [63:0] data;
        logic stable, done;
        do_reset();
        update_req = 1'b1;
        write_ch(3'd2, 16'h4242);
        update_req = 1'b0;
        checks++; if (busy !== 1'b1 || dac_valid !== 1'b0) begin errors++; $display("FAIL wu_load: got busy %b valid %b want 1 0", busy, dac_valid); end
        tick();
        checks++; if (dac_valid !== 1'b1 || dac_data !== 64'h8000_4242_8000_8000) begin errors++; $display("FAIL wu_data: got valid %b data %h want 1 8000424280008000", dac_valid, dac_data); end
        run_frame(gap, len, data, stable, done);
        checks++; if (len != FRAME || done !== 1'b1) begin errors++; $display("FAIL wu_len: got %0d done %b want %0d 1", len, done, FRAME); end
        seen = 0;
        repeat (300) begin
            tick();
            if (dac_valid) seen++;
        end
        checks++; if (seen != 0 || frame_cnt !== 16'd1) begin errors++; $display("FAIL wu_single: got %0d extra valid cnt %0d want 0 1", seen, frame_cnt); end
    endtask

    task automatic test_refresh();
        int n, len, n2;
        logic [63:0] data;
        rst_r = 1'b1;
        tick();
        rst_r = 1'b0;
        n = 0;
        while (!dac_valid_r && n < 4000) begin
            tick();
            n++;
        end
        checks++; if (n != 3001) begin errors++; $display("FAIL ref_first: got %0d cycles want 3001", n); end
        data = dac_data_r;
        checks++; if (data !== 64'h8000_8000_8000_8000) begin errors++; $display("FAIL ref_data: got %h want 8000800080008000", data); end
        len = 0;
        while (dac_valid_r && len < 2000) begin
            tick();
            len++;
        end
        checks++; if (len != FRAME || frame_cnt_r !== 16'd1) begin errors++; $display("FAIL ref_frame1: got len %0d cnt %0d want %0d 1", len, frame_cnt_r, FRAME); end
        force dut_r.frame_cnt = 16'hFFFF;
        tick();
        release dut_r.frame_cnt;
        tick();
        checks++; if (frame_cnt_r !== 16'hFFFF) begin errors++; $display("FAIL ref_preload: got %h want ffff", frame_cnt_r); end
        n2 = len + 2;
        while (!dac_valid_r && n2 < 4000) begin
            tick();
            n2++;
        end
        checks++; if (n2 != 3000) begin errors++; $display("FAIL ref_period: got %0d cycles want 3000", n2); end
        len = 0;
        while (dac_valid_r && len < 2000) begin
            tick();
            len++;
        end
        checks++; if (len != FRAME || frame_done_r !== 1'b1) begin errors++; $display("FAIL ref_frame2: got len %0d done %b want %0d 1", len, frame_done_r, FRAME); end
        checks++; if (frame_cnt_r !== 16'h0000) begin errors++; $display("FAIL ref_wrap: got %h want 0000", frame_cnt_r); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_coalesce();
        test_load_write();
        test_reset_mid_frame();
        test_back_to_back();
        test_refresh();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
